// File: rtl/luma_arb_pkg.sv
// luma_arb_pkg: shared types and sizing helpers for the luma arbiter.
//   state_t  : triplet phase of the granted requester (IDLE, PH_R, PH_G, PH_B)
//   NREQ_DEF : default requester count
//   id_width : requester-ID width for a given requester count (minimum 1)
package luma_arb_pkg;
  typedef enum logic [1:0] {IDLE, PH_R, PH_G, PH_B} state_t;
  localparam int NREQ_DEF = 2;
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/luma_tag_fifo.sv
// luma_tag_fifo: two-entry FIFO of requester tags awaiting their luma result.
//   clk, rst   : clock, asynchronous active-low reset
//   push, din  : enqueue a tag (dropped when full unless a pop frees a slot)
//   pop, dout  : dequeue; dout always shows the oldest entry
//   full, empty: occupancy flags
module luma_tag_fifo #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic wp, rp, do_push, do_pop;
  logic [1:0] cnt;
  assign empty   = cnt == 2'd0;
  assign full    = cnt == 2'd2;
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot the push lands in
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/luma_arbiter.sv
// luma_arbiter: round-robin sharing of one byte-serial rgb2luma datapath.
//   clk, rst                 : clock, asynchronous active-low reset
//   req_data/valid/ready     : per-requester R,G,B byte streams
//   luma_data_o/luma_valid_o : bytes forwarded to rgb2luma
//   luma_data_i/luma_valid_i : luma returned by rgb2luma
//   res_data/res_valid/res_id: registered result and owning requester
//   busy                     : triplet in progress or result outstanding
//   err                      : sticky; orphan result or tag overflow
module luma_arbiter import luma_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0][7:0] req_data,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  output logic [7:0]           luma_data_o,
  output logic                 luma_valid_o,
  input  logic [7:0]           luma_data_i,
  input  logic                 luma_valid_i,
  output logic [7:0]           res_data,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic                 busy,
  output logic                 err
);
  state_t state;
  logic [IDW-1:0] g, rr_ptr, nxt_ptr, base, pick, tag;
  logic xfer, last, full, empty;

  function automatic logic [IDW-1:0] wrap(input int i);
    return IDW'(i >= NREQ ? i - NREQ : i);
  endfunction

  assign xfer    = (state != IDLE) & req_valid[g];
  assign last    = xfer & (state == PH_B);
  assign nxt_ptr = wrap(int'(g) + 1);
  // the triplet's final byte re-arbitrates against the already-advanced pointer
  assign base    = last ? nxt_ptr : rr_ptr;

  // descending scan so the nearest valid requester at or after base wins
  always_comb begin
    pick = base;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[wrap(int'(base) + k)]) pick = wrap(int'(base) + k);
  end

  always_comb begin
    req_ready = '0;
    if (state != IDLE) req_ready[g] = 1'b1;
  end

  assign luma_data_o  = req_data[g];
  assign luma_valid_o = xfer;
  assign busy         = (state != IDLE) | ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      g      <= '0;
      rr_ptr <= '0;
    end else if (state == IDLE) begin
      if (|req_valid) begin
        g     <= pick;
        state <= PH_R;
      end
    end else if (xfer) begin
      if (state == PH_R) state <= PH_G;
      else if (state == PH_G) state <= PH_B;
      else begin
        rr_ptr <= nxt_ptr;
        if (|req_valid) begin
          g     <= pick;
          state <= PH_R;
        end else state <= IDLE;
      end
    end
  end

  luma_tag_fifo #(.W(IDW)) u_tags (
    .clk  (clk),
    .rst  (rst),
    .push (last),
    .pop  (luma_valid_i),
    .din  (g),
    .dout (tag),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data  <= 8'h00;
      res_valid <= 1'b0;
      res_id    <= '0;
      err       <= 1'b0;
    end else begin
      res_valid <= luma_valid_i & ~empty;
      if (luma_valid_i & ~empty) begin
        res_data <= luma_data_i;
        res_id   <= tag;
      end
      if ((luma_valid_i & empty) | (last & full & ~luma_valid_i)) err <= 1'b1;
    end
  end
endmodule
